// File: rtl/mem_bus_port_pkg.sv
// Shared definitions for the memory-side bus port: FSM state encoding and op codes.
package mem_bus_port_pkg;

   typedef enum logic [1:0] {
      MBP_IDLE    = 2'd0,
      MBP_WAIT    = 2'd1,
      MBP_DONE    = 2'd2,
      MBP_RELEASE = 2'd3
   } mbp_state_e;

   typedef enum logic {
      MBP_OP_READ  = 1'b0,
      MBP_OP_WRITE = 1'b1
   } mbp_op_e;

   // Wait-state counter holds LATENCY-1, LATENCY is at most 15
   localparam int MBP_CNT_W = 4;

endpackage

// File: rtl/mem_bus_port_if.sv
// Core-to-memory bus: level requests from the core, done pulses and read data back.
interface mem_bus_port_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              read_q;
   logic              write_q;
   logic [ADDR_W-1:0] addr_in;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              read_dn;
   logic              write_dn;
   logic              bus_busy;
   logic              mem_err;

   modport master (
      output read_q, write_q, addr_in, data_in,
      input  data_out, read_dn, write_dn, bus_busy, mem_err
   );

   modport slave (
      input  read_q, write_q, addr_in, data_in,
      output data_out, read_dn, write_dn, bus_busy, mem_err
   );
endinterface

// File: rtl/mem_bus_port_ram.sv
// Single-port synchronous RAM (DEPTH x DATA_W) with write enable and registered read.
module mem_bus_ram #(
   parameter int DEPTH  = 1024,
   parameter int DATA_W = 32,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [IDX_W-1:0]  addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_bus_port.sv
// Memory-side bus port: services held read/write levels after LATENCY wait states.
// Optional MEM_BUS_PORT_RANGE_CHK_EN flags addresses beyond DEPTH instead of wrapping.
module mem_bus_port
   import mem_bus_port_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic           clk,
   input  logic           rst,
   mem_bus_port_if.slave  bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [MBP_CNT_W-1:0] CNT_INIT =
      (LATENCY > 0) ? MBP_CNT_W'(LATENCY - 1) : '0;

   mbp_state_e            state_q, state_d;
   logic [MBP_CNT_W-1:0]  cnt_q, cnt_d;
   mbp_op_e               op_q, op_d;
   logic [IDX_W-1:0]      addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic                  err_active;
   logic                  range_bad;

   logic                  req_any;
   logic                  req_held;

   logic                  ram_we;
   logic                  ram_re;
   logic [IDX_W-1:0]      ram_addr;
   logic [DATA_W-1:0]     ram_rdata;

`ifdef MEM_BUS_PORT_RANGE_CHK_EN
   logic err_q, err_d;
   assign range_bad  = (bus.addr_in >> IDX_W) != '0;
   assign err_active = err_q;
`else
   assign range_bad  = 1'b0;
   assign err_active = 1'b0;
`endif

   assign req_any  = bus.read_q | bus.write_q;
   // Only the line of the operation being serviced keeps the transaction alive
   assign req_held = (op_q == MBP_OP_WRITE) ? bus.write_q : bus.read_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= MBP_IDLE;
         cnt_q   <= '0;
         op_q    <= MBP_OP_READ;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef MEM_BUS_PORT_RANGE_CHK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef MEM_BUS_PORT_RANGE_CHK_EN
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef MEM_BUS_PORT_RANGE_CHK_EN
      err_d   = err_q;
`endif
      unique case (state_q)
         MBP_IDLE: begin
            if (req_any) begin
               // Write wins a tie; the read stays pending on its own level
               op_d    = bus.write_q ? MBP_OP_WRITE : MBP_OP_READ;
               addr_d  = bus.addr_in[IDX_W-1:0];
               wdata_d = bus.data_in;
               cnt_d   = CNT_INIT;
               state_d = (LATENCY > 0) ? MBP_WAIT : MBP_DONE;
`ifdef MEM_BUS_PORT_RANGE_CHK_EN
               err_d   = range_bad;
`endif
            end
         end
         MBP_WAIT: begin
            if (!req_held) begin
               state_d = MBP_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = MBP_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         MBP_DONE: begin
            state_d = MBP_RELEASE;
         end
         MBP_RELEASE: begin
            if (!req_held) begin
               state_d = MBP_IDLE;
            end
         end
         default: state_d = MBP_IDLE;
      endcase
   end

   // Read address goes out one cycle before DONE so registered RAM data lines up
   always_comb begin
      ram_addr = (state_q == MBP_IDLE) ? bus.addr_in[IDX_W-1:0] : addr_q;
      ram_re   = ((state_q == MBP_IDLE) && req_any && (LATENCY == 0)) ||
                 ((state_q == MBP_WAIT) && (cnt_q == '0));
      ram_we   = (state_q == MBP_DONE) && (op_q == MBP_OP_WRITE) && !err_active;
   end

   always_comb begin
      bus.bus_busy = (state_q != MBP_IDLE);
      bus.read_dn  = (state_q == MBP_DONE) && (op_q == MBP_OP_READ);
      bus.write_dn = (state_q == MBP_DONE) && (op_q == MBP_OP_WRITE);
      bus.mem_err  = (state_q == MBP_DONE) && err_active;
      bus.data_out = '0;
      if ((state_q == MBP_DONE) && (op_q == MBP_OP_READ) && !err_active) begin
         bus.data_out = ram_rdata;
      end
   end

   mem_bus_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (ram_addr),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

   // Upper address bits only matter when range checking is built in
   logic unused_range;
   assign unused_range = range_bad;

endmodule
